// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared md_op encodings and cycle counts for the mult/div unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MSUB  = 3'd7
    } md_op_e;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : Issue/result bundle between the E stage and the mult/div unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, md_op, A, B, input  busy, HI, LO);
    modport slave  (input  start, md_op, A, B, output busy, HI, LO);
endinterface : muldiv_if
`default_nettype wire

// File: rtl/muldiv.sv
`default_nettype none
// ============================================================================
// Module   : muldiv
// Brief    : Multi-cycle HI/LO multiply/divide unit with fixed latency.
//            Build macro MULDIV_MADD_EN enables the MADD/MSUB accumulate ops.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv (
    input  wire logic clk,
    input  wire logic reset,
    muldiv_if.slave   bus
);
    import muldiv_pkg::*;

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_pend;

    logic        w_op_ok;
    logic        w_accept;
    logic        w_div_signed;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_pend;

`ifdef MULDIV_MADD_EN
    logic [63:0] w_acc;
    assign w_op_ok = 1'b1;
    assign w_acc   = (bus.md_op == MD_MSUB) ? ({r_hi, r_lo} - w_prod_s)
                                            : ({r_hi, r_lo} + w_prod_s);
`else
    // Accumulate encodings behave exactly like an idle cycle.
    assign w_op_ok = (bus.md_op != MD_MADD) && (bus.md_op != MD_MSUB);
`endif

    assign w_accept = bus.start && (r_state == c_idle) && w_op_ok;

    // Low 64 bits of a 64x64 product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign w_div_signed = (bus.md_op == MD_DIV);
    assign w_a_mag      = (w_div_signed && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    assign w_b_mag      = (w_div_signed && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
    assign w_divisor    = (bus.B == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_divisor;
    assign w_r_mag      = w_a_mag % w_divisor;
    assign w_q = (w_div_signed && (bus.A[31] ^ bus.B[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r = (w_div_signed && bus.A[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        w_pend = {r_hi, r_lo};
        case (bus.md_op)
            MD_MULT:  w_pend = w_prod_s;
            MD_MULTU: w_pend = w_prod_u;
            MD_DIV,
            MD_DIVU:  w_pend = (bus.B == 32'd0) ? {r_hi, r_lo} : {w_r, w_q};
`ifdef MULDIV_MADD_EN
            MD_MADD,
            MD_MSUB:  w_pend = w_acc;
`endif
            default:  w_pend = {r_hi, r_lo};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_pend  <= 64'd0;
        end else if (r_state == c_idle) begin
            if (w_accept) begin
                if (bus.md_op == MD_MTHI) begin
                    r_hi <= bus.A;
                end else if (bus.md_op == MD_MTLO) begin
                    r_lo <= bus.A;
                end else begin
                    r_pend  <= w_pend;
                    r_cnt   <= is_div(bus.md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    r_state <= c_run;
                end
            end
        end else begin
            // Result is committed on the last busy edge so it appears with busy=0.
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                {r_hi, r_lo} <= r_pend;
                r_state      <= c_idle;
            end
        end
    end

    assign bus.busy = (r_state == c_run);
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule : muldiv
`default_nettype wire

// File: tb/tb_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv
// Brief    : Directed self-checking bench for muldiv (HI/LO unit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_if bus ();

    muldiv u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op, checks busy/hold for 'cycles' cycles, then the committed result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cycles,
                          input logic [31:0] ehi, input logic [31:0] elo);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            check({tag, " busy"}, 64'(bus.busy), 64'd1);
            check({tag, " hold"}, {bus.HI, bus.LO}, {m_hi, m_lo});
            step();
        end
        check({tag, " done"}, 64'(bus.busy), 64'd0);
        check({tag, " hilo"}, {bus.HI, bus.LO}, {ehi, elo});
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        step();
        step();
        reset = 1'b0;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset hilo", {bus.HI, bus.LO}, 64'd0);

        run_op("mult",     3'd0, 32'hFFFF_FFFE, 32'd3,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("mult nn",  3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFC,  5,  32'h0000_0000, 32'h0000_000C);
        run_op("div",      3'd2, 32'hFFFF_FFF9, 32'd2,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",     3'd3, 32'd7,         32'd2,          10, 32'd1,         32'd3);
        run_op("div ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  10, 32'd0,         32'h8000_0000);
        run_op("mthi",     3'd4, 32'h0000_1234, 32'd0,          0,  32'h0000_1234, 32'h8000_0000);
        run_op("div0",     3'd2, 32'd5,         32'd0,          10, 32'h0000_1234, 32'h8000_0000);

        // Second start two cycles into a MULTU must be dropped.
        bus.start = 1'b1; bus.md_op = 3'd1; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
        step();
        bus.start = 1'b0;
        check("sbusy t1", 64'(bus.busy), 64'd1);
        step();
        bus.start = 1'b1; bus.md_op = 3'd3; bus.A = 32'd7; bus.B = 32'd2;
        step();
        bus.start = 1'b0;
        check("sbusy t3", 64'(bus.busy), 64'd1);
        check("sbusy hold", {bus.HI, bus.LO}, {m_hi, m_lo});
        step();
        step();
        check("sbusy t5", 64'(bus.busy), 64'd1);
        step();
        check("sbusy t6 busy", 64'(bus.busy), 64'd0);
        check("sbusy t6 hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);
        step();
        check("sbusy t7 busy", 64'(bus.busy), 64'd0);
        check("sbusy t7 hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);

        // Reset at T+3 of a DIV discards the pending result.
        bus.start = 1'b1; bus.md_op = 3'd2; bus.A = 32'd100; bus.B = 32'd3;
        step();
        bus.start = 1'b0;
        check("rmid t1", 64'(bus.busy), 64'd1);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmid busy", 64'(bus.busy), 64'd0);
        check("rmid hilo", {bus.HI, bus.LO}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        step();
        run_op("post rst", 3'd0, 32'd6, 32'd7, 5, 32'd0, 32'd42);
        step();
        check("div0 after", {bus.HI, bus.LO}, 64'd42);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        bus.start = 1'b1; bus.md_op = 3'd0; bus.A = 32'd3; bus.B = 32'd3;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        check("rprio busy", 64'(bus.busy), 64'd0);
        check("rprio hilo", {bus.HI, bus.LO}, 64'd0);
        m_lo = 32'd0;
        step();
        check("rprio idle", 64'(bus.busy), 64'd0);

        run_op("mtlo", 3'd5, 32'd10, 32'd0, 0, 32'd0, 32'd10);
`ifdef MULDIV_MADD_EN
        run_op("madd",      3'd6, 32'd2,         32'd3, 5, 32'd0,         32'd16);
        run_op("msub neg",  3'd7, 32'hFFFF_FFFF, 32'd1, 5, 32'd0,         32'd17);
        run_op("mtlo0",     3'd5, 32'd0,         32'd0, 0, 32'd0,         32'd0);
        run_op("msub wrap", 3'd7, 32'd1,         32'd1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
        run_op("madd off",  3'd6, 32'd2,         32'd3, 0, 32'd0,         32'd10);
        run_op("msub off",  3'd7, 32'd2,         32'd3, 0, 32'd0,         32'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_muldiv
`default_nettype wire

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: E-stage pulse that issues md_op this cycle.
REQ-004 The block SHALL have port md_op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-005 The block SHALL have port A, input, 32 bits: rs operand, already forwarded.
REQ-006 The block SHALL have port B, input, 32 bits: rt operand, already forwarded.
REQ-007 The block SHALL have port busy, output, 1 bit: operation in flight; it feeds the hazard unit's busy input.
REQ-008 The block SHALL have port HI, output, 32 bits: architectural HI register.
REQ-009 The block SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-010 The FSM SHALL have states IDLE and RUN, plus a 4-bit down-counter cnt.
- IDLE + start + op in {0,1,6,7}: load cnt=5, go to RUN.
- IDLE + start + op in {2,3}: load cnt=10, go to RUN.
REQ-011 busy SHALL equal (state==RUN); for start at cycle T, busy=1 in cycles T+1..T+5 (mult) or T+1..T+10 (div).
REQ-012 The block SHALL latch operands and compute the result into pending registers at the start edge; HI/LO SHALL change only on the final RUN edge, so the new value and busy=0 first appear in the same cycle (T+6 for mult, T+11 for div).
REQ-013 HI/LO SHALL hold their old values throughout RUN.
REQ-014 MTHI/MTLO SHALL write A to HI/LO at the start edge, visible at T+1, and SHALL NOT assert busy.
REQ-015 start while busy=1 SHALL be ignored entirely; the in-flight operation completes unchanged.
REQ-016 MULT SHALL produce {HI,LO} = signed 64-bit A*B; MULTU SHALL produce the unsigned 64-bit product.
REQ-017 DIV SHALL be signed: LO=quotient truncated toward zero, HI=remainder with the sign of A. For 0x80000000 / 0xFFFFFFFF it SHALL give LO=0x80000000, HI=0.
REQ-018 DIVU SHALL be unsigned: LO=quotient, HI=remainder.
REQ-019 Divide by zero (B==0) SHALL still run 10 busy cycles and SHALL leave HI/LO unchanged; the output is never X.
REQ-020 MADD/MSUB SHALL produce {HI,LO} = {HI,LO} +/- signed A*B, using the HI/LO sampled at the start edge and wrapping modulo 2^64.
REQ-021 start=0 SHALL leave all state unchanged.

Reset
REQ-022 When reset=1 at a clock edge, the block SHALL set HI=0, LO=0, busy=0, state=IDLE, cnt=0.
REQ-023 Reset mid-operation SHALL discard the pending result, so HI/LO read 0 afterwards.
REQ-024 Reset SHALL have priority over a start in the same cycle.

Configuration
REQ-025 Macro MULDIV_MADD_EN SHALL control the accumulate ops.
- Defined: MADD/MSUB behave per REQ-020.
- Undefined: md_op 6/7 SHALL be treated as start=0 (no busy, no HI/LO change), and the accumulate adder SHALL be absent from the netlist.

Structure
REQ-026 Shared package muldiv_pkg SHALL hold the md_op encodings (MD_MULT..MD_MSUB), MULT_CYCLES=5 and DIV_CYCLES=10.
- The instruction decoder uses the same encodings to drive md_op.
- The hazard unit uses the same encodings to classify md/mt/mf instructions.
REQ-027 There SHALL be no sub-module; the block is a single module with the FSM, counter, pending registers and arithmetic.

Verification
REQ-028 MULT test: start, op=0, A=0xFFFFFFFE (-2), B=3 at T -> busy=1 for T+1..T+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+6.
REQ-029 DIV test: start, op=2, A=-7, B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Repeat with DIVU, A=7, B=2 -> LO=3, HI=1.
REQ-030 Divide-by-zero and MTHI test:
- MTHI A=0x1234 -> HI=0x1234 at T+1 with busy=0 throughout.
- Then DIV with B=0 -> 10 busy cycles, HI stays 0x1234.
REQ-031 Start-while-busy test: MULTU A=B=0xFFFFFFFF, then a second start (DIVU) at T+2 -> the second start is ignored; HI=0xFFFFFFFE, LO=0x00000001 at T+6.
REQ-032 Reset mid-operation test: assert reset at T+3 of a DIV -> busy=0 and HI=LO=0 at T+4; a new MULT issued at T+5 completes normally.
REQ-033 Accumulate test with MULDIV_MADD_EN defined: HI=0, LO=10, then MADD A=2, B=3 -> LO=16 after 5 busy cycles. With the macro undefined, op=6 -> busy stays 0 and LO stays 10.
